// File: rtl/riscv_fetch.sv
// ============================================================================
//  Module   : riscv_fetch
//  Purpose  : In-order instruction fetch unit with response buffer and redirect.
//  Options  : RISCV_FETCH_BYPASS_EN - an empty buffer forwards a response to decode
//             in the same cycle it arrives.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_fetch #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0,
    parameter int                     FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WORD_LENGTH-1:0] imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [WORD_LENGTH-1:0] imem_rsp_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [WORD_LENGTH-1:0] inst,
    output logic [WORD_LENGTH-1:0] inst_pc,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_pc
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    logic [WORD_LENGTH-1:0] r_fetch_pc;
    logic [WORD_LENGTH-1:0] r_rsp_pc;
    logic [c_cnt_w-1:0]     r_outstanding;
    logic [c_cnt_w-1:0]     r_drop_cnt;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [WORD_LENGTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [WORD_LENGTH-1:0] r_fifo_pc   [FIFO_DEPTH];

    logic [c_cnt_w:0]       w_inflight;
    logic                   w_req_fire;
    logic                   w_rsp_live;
    logic                   w_rsp_drop;
    logic                   w_fifo_nonempty;
    logic                   w_bypass;
    logic                   w_bypass_take;
    logic                   w_push;
    logic                   w_pop;
    logic [WORD_LENGTH-1:0] w_redir_pc;

    assign w_inflight      = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid  = !rst && !redirect_valid
                             && (w_inflight < (c_cnt_w + 1)'(FIFO_DEPTH));
    assign imem_req_addr   = r_fetch_pc;
    assign w_req_fire      = imem_req_valid && imem_req_ready;
    assign w_redir_pc      = redirect_pc & ~WORD_LENGTH'(3);

    assign w_rsp_live      = imem_rsp_valid && (r_drop_cnt == '0);
    assign w_rsp_drop      = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_fifo_nonempty = (r_count != '0);

`ifdef RISCV_FETCH_BYPASS_EN
    assign w_bypass = !w_fifo_nonempty && w_rsp_live && !redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_bypass_take = w_bypass && inst_ready;

    assign w_push = w_rsp_live && !w_bypass_take && !redirect_valid;
    assign w_pop  = w_fifo_nonempty && inst_ready && !redirect_valid;

    assign inst_valid = !rst && (w_fifo_nonempty || w_bypass);
    assign inst       = w_fifo_nonempty ? r_fifo_data[r_rd_ptr] :
                        w_bypass        ? imem_rsp_data : '0;
    assign inst_pc    = w_fifo_nonempty ? r_fifo_pc[r_rd_ptr] :
                        w_bypass        ? r_rsp_pc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(imem_rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                // Outstanding already includes the pending drops, so after this
                // cycle's decrement it is exactly the number of stale words left.
                r_drop_cnt <= r_outstanding - c_cnt_w'(imem_rsp_valid);
                r_rd_ptr   <= r_wr_ptr;
                r_count    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + WORD_LENGTH'(4);
                end
                if (w_rsp_live) begin
                    r_rsp_pc <= r_rsp_pc + WORD_LENGTH'(4);
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    // Buffer storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rsp_data;
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch.sv
// ============================================================================
//  Module   : tb_riscv_fetch
//  Purpose  : Randomized self-checking bench for riscv_fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_fetch;

    localparam int WL    = 32;
    localparam int DEPTH = 2;
`ifdef RISCV_FETCH_BYPASS_EN
    localparam logic [31:0] BYP = 32'd1;
`else
    localparam logic [31:0] BYP = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [WL-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [WL-1:0] imem_rsp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [WL-1:0] inst;
    logic [WL-1:0] inst_pc;
    logic          redirect_valid;
    logic [WL-1:0] redirect_pc;

    riscv_fetch #(
        .WORD_LENGTH (WL),
        .RESET_PC    (32'h0000_0000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          consumed = 0;
    int          p_req, p_rsp, p_inst, p_redir;
    bit          frc, lat_arm, after_redir;
    logic [31:0] frc_pc;
    logic [31:0] exp_req_addr, exp_inst_pc;
    logic [31:0] q_addr[$];
    int          q_due[$];

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, judge the settled outputs,
    // then let the rising edge commit whatever handshakes were visible.
    task automatic step();
        logic rsp_now;
        logic fire;
        @(negedge clk);
        inst_ready     = ($urandom_range(0, 99) < p_inst);
        imem_req_ready = ($urandom_range(0, 99) < p_req);
        if (frc) begin
            redirect_valid = 1'b1;
            redirect_pc    = frc_pc;
            frc            = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(0, 999) < p_redir);
            redirect_pc    = $urandom;
        end
        rsp_now = (q_addr.size() > 0) && (q_due[0] <= cyc) && ($urandom_range(0, 99) < p_rsp);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? memf(q_addr[0]) : $urandom;
        #1;
        if (after_redir) check("flush_empty", 32'(inst_valid), 32'd0);
        after_redir = 1'b0;
        if (lat_arm && rsp_now) begin
            check("first_rsp_valid", 32'(inst_valid), BYP);
            lat_arm = 1'b0;
        end
        fire = imem_req_valid && imem_req_ready;
        if (redirect_valid) begin
            check("req_gated", 32'(imem_req_valid), 32'd0);
            exp_req_addr = redirect_pc & ~32'd3;
            exp_inst_pc  = redirect_pc & ~32'd3;
            after_redir  = 1'b1;
        end else begin
            if (imem_req_valid) check("credit", 32'(q_addr.size() < DEPTH), 32'd1);
            if (fire) begin
                check("req_addr", imem_req_addr, exp_req_addr);
                exp_req_addr += 32'd4;
            end
            if (inst_valid && inst_ready) begin
                check("inst_pc", inst_pc, exp_inst_pc);
                check("inst", inst, memf(exp_inst_pc));
                exp_inst_pc += 32'd4;
                consumed++;
            end
        end
        if (rsp_now) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (fire) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + 1);
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        frc = 1'b0; lat_arm = 1'b0; after_redir = 1'b0;
        exp_req_addr = 32'h0; exp_inst_pc = 32'h0;
        #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Streaming with a 1-cycle memory and a always-ready decoder
        p_req = 100; p_rsp = 100; p_inst = 100; p_redir = 0;
        lat_arm = 1'b1;
        c0 = consumed;
        repeat (30) step();
        check("stream_progress", 32'(consumed - c0 >= 10), 32'd1);

        // Decoder stalls: the unit must fill and then stop requesting
        p_inst = 0;
        repeat (12) step();
        check("stall_no_req", 32'(imem_req_valid), 32'd0);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        check("stall_inst_pc", inst_pc, exp_inst_pc);
        p_inst = 100;
        repeat (10) step();

        // Two requests in flight when a misaligned redirect arrives
        p_rsp = 0;
        repeat (6) step();
        check("two_outstanding", 32'(q_addr.size()), 32'd2);
        frc = 1'b1; frc_pc = 32'h0000_0103;
        step();
        p_rsp = 100;
        c0 = consumed;
        repeat (15) step();
        check("redir_progress", 32'(consumed - c0 >= 3), 32'd1);

        // Address wrap at the top of the space
        frc = 1'b1; frc_pc = 32'hFFFF_FFF8;
        step();
        repeat (20) step();

        // Randomized traffic with occasional redirects
        c0 = consumed;
        for (int blk = 0; blk < 15; blk++) begin
            p_req   = $urandom_range(30, 100);
            p_rsp   = $urandom_range(30, 100);
            p_inst  = $urandom_range(20, 100);
            p_redir = $urandom_range(0, 30);
            repeat (200) step();
        end
        check("random_progress", 32'(consumed - c0 >= 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
